// File: rtl/led_pkg.sv
// Shared definitions for the LED driver path: serializer state encoding,
// default frame geometry shared with the frame timer and pixel source, and
// a counter-width helper.
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_LATCH     = 3'd3,
    ST_DONE      = 3'd4
  } led_state_t;

  localparam int LED_WORD_WIDTH      = 16;
  localparam int LED_WORDS_PER_FRAME = 12;
  localparam int LED_CLK_DIV         = 4;
  localparam int LED_LATCH_CYCLES    = 8;

  // Bits needed to hold every value 0..max_value (never less than one bit).
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_bit_tick.sv
// Serial-clock divider for the LED driver bus. While enabled it counts
// CLK_DIV system cycles per half-period, flips the phase at each terminal
// count and flags the end of each full bit (end of a high phase). Disabling
// it returns it to the start of a low phase.
module led_bit_tick
  import led_pkg::*;
#(
  parameter int CLK_DIV = LED_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase,
  output logic toggle,
  output logic bit_end
);

  localparam int DW = cnt_width(CLK_DIV - 1);
  localparam logic [DW-1:0] TC = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  assign toggle  = en && (cnt == TC);
  assign bit_end = toggle && phase;

  // Half-period counter and phase flag; both cleared whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= toggle ? '0 : cnt + 1'b1;
      phase <= phase ^ toggle;
    end
  end

endmodule

// File: rtl/led_serializer.sv
// LED driver serializer. On a frame-start strobe it pulls WORDS_PER_FRAME
// words over valid/ready, shifts each MSB-first onto o_clk/o_dai, then
// pulses o_lat for LATCH_CYCLES cycles and flags o_done for one cycle.
// All outputs are registered from the next-state values so they line up
// with the state they describe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for i_start; i_valid ignored
// WAIT_WORD  | o_ready high, o_clk held low until a word is accepted
// SHIFT      | shifting current word, CLK_DIV cycles per serial half-period
// LATCH      | o_lat high for LATCH_CYCLES cycles, o_clk/o_dai low
// DONE       | one-cycle o_done, then back to IDLE
module led_serializer
  import led_pkg::*;
#(
  parameter int WORD_WIDTH      = LED_WORD_WIDTH,
  parameter int WORDS_PER_FRAME = LED_WORDS_PER_FRAME,
  parameter int CLK_DIV         = LED_CLK_DIV,
  parameter int LATCH_CYCLES    = LED_LATCH_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_clk,
  output logic                  o_dai,
  output logic                  o_lat
);

  localparam int BW  = cnt_width(WORD_WIDTH - 1);
  localparam int WCW = cnt_width(WORDS_PER_FRAME);
  localparam int LW  = cnt_width(LATCH_CYCLES - 1);

  localparam logic [BW-1:0]  BIT_LOAD  = BW'(WORD_WIDTH - 1);
  localparam logic [WCW-1:0] WORDS_END = WCW'(WORDS_PER_FRAME);
  localparam logic [LW-1:0]  LAT_LOAD  = LW'(LATCH_CYCLES - 1);

  led_state_t state, state_nx;

  logic [WORD_WIDTH-1:0] sr, sr_nx;
  logic [BW-1:0]         bit_cnt, bit_cnt_nx;
  logic [WCW-1:0]        word_cnt, word_cnt_nx;
  logic [LW-1:0]         lat_cnt, lat_cnt_nx;

  logic ready_nx, busy_nx, done_nx, clk_nx, dai_nx, lat_nx;

  logic tick_en, phase, toggle, bit_end;

  assign tick_en = (state == ST_SHIFT);

  led_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_tick (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (tick_en),
    .phase   (phase),
    .toggle  (toggle),
    .bit_end (bit_end)
  );

  // Next-state, datapath and output decisions.
  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    bit_cnt_nx  = bit_cnt;
    word_cnt_nx = word_cnt;
    lat_cnt_nx  = lat_cnt;
    dai_nx      = o_dai;
    clk_nx      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nx    = ST_WAIT_WORD;
          word_cnt_nx = '0;
        end
      end

      ST_WAIT_WORD: begin
        if (i_valid && o_ready) begin
          sr_nx      = i_data;
          bit_cnt_nx = BIT_LOAD;
          dai_nx     = i_data[WORD_WIDTH-1];
          state_nx   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // o_clk follows the divider phase, flipping on each terminal count.
        clk_nx = phase ^ toggle;
        if (bit_end) begin
          if (bit_cnt == '0) begin
            word_cnt_nx = word_cnt + 1'b1;
            clk_nx      = 1'b0;
            dai_nx      = 1'b0;
            if (word_cnt_nx == WORDS_END) begin
              state_nx   = ST_LATCH;
              lat_cnt_nx = LAT_LOAD;
            end else begin
              state_nx = ST_WAIT_WORD;
            end
          end else begin
            // New data bit goes out together with the falling serial clock.
            sr_nx      = sr << 1;
            dai_nx     = sr_nx[WORD_WIDTH-1];
            bit_cnt_nx = bit_cnt - 1'b1;
          end
        end
      end

      ST_LATCH: begin
        dai_nx = 1'b0;
        if (lat_cnt == '0) begin
          state_nx = ST_DONE;
        end else begin
          lat_cnt_nx = lat_cnt - 1'b1;
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    ready_nx = (state_nx == ST_WAIT_WORD);
    busy_nx  = (state_nx != ST_IDLE);
    lat_nx   = (state_nx == ST_LATCH);
    done_nx  = (state_nx == ST_DONE);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Shift register and frame counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      sr       <= sr_nx;
      bit_cnt  <= bit_cnt_nx;
      word_cnt <= word_cnt_nx;
      lat_cnt  <= lat_cnt_nx;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_clk   <= 1'b0;
      o_dai   <= 1'b0;
      o_lat   <= 1'b0;
    end else begin
      o_ready <= ready_nx;
      o_busy  <= busy_nx;
      o_done  <= done_nx;
      o_clk   <= clk_nx;
      o_dai   <= dai_nx;
      o_lat   <= lat_nx;
    end
  end

endmodule

// File: tb/tb_led_serializer.sv
// Bench for led_serializer: directed frames plus random frames, checked
// against frame-level expectations (bit stream, edge count, latch/done
// timing) and continuously monitored pin-timing rules.
module tb_led_serializer;

  localparam int WW  = 16;
  localparam int WPF = 2;
  localparam int DIV = 2;
  localparam int LAT = 4;
  localparam int NB  = WW * WPF;

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_valid;
  logic [WW-1:0] i_data;
  logic          o_ready, o_busy, o_done, o_clk, o_dai, o_lat;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;
  int accepted = 0;

  // Monitor results for the current frame.
  logic bits[$];
  int   dai_viol, phase_viol, lat_viol, idle_viol;
  int   lat_first, lat_count, done_count, done_cyc;
  int   high_run, low_run;
  logic prev_clk, prev_dai;

  logic [WW-1:0] words[WPF];

  led_serializer #(
    .WORD_WIDTH      (WW),
    .WORDS_PER_FRAME (WPF),
    .CLK_DIV         (DIV),
    .LATCH_CYCLES    (LAT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_clk   (o_clk),
    .o_dai   (o_dai),
    .o_lat   (o_lat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake counter: values sampled just before the edge.
  always @(posedge clk) begin
    if (!i_rst && o_ready && i_valid) accepted = accepted + 1;
  end

  // Pin monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (i_rst) begin
      prev_clk = 1'b0;
      prev_dai = 1'b0;
      high_run = 0;
      low_run  = 0;
    end else begin
      if (o_clk && !prev_clk) bits.push_back(o_dai);
      if (o_clk && (o_dai !== prev_dai)) dai_viol++;
      if (o_clk !== prev_clk) begin
        if (prev_clk) begin
          if (high_run != DIV) phase_viol++;
        end else begin
          if (low_run != DIV) phase_viol++;
        end
        high_run = 0;
        low_run  = 0;
      end
      if (o_clk) high_run++;
      else if (o_busy && !o_ready && !o_lat && !o_done) low_run++;
      else low_run = 0;
      if (o_lat) begin
        if (lat_count == 0) lat_first = cyc - start_cyc;
        lat_count++;
        if (o_clk) lat_viol++;
      end
      if (o_done) begin
        done_count++;
        done_cyc = cyc - start_cyc;
      end
      if (o_ready && !o_busy) idle_viol++;
      prev_clk = o_clk;
      prev_dai = o_dai;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bits.delete();
    dai_viol = 0; phase_viol = 0; lat_viol = 0; idle_viol = 0;
    lat_first = -1; lat_count = 0; done_count = 0; done_cyc = -1;
  endtask

  // One frame: start at cycle 0, keep i_valid high except for 'stall'
  // cycles of the wait before the second word; optionally pulse i_start
  // during SHIFT, LATCH and DONE.
  task automatic run_frame(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input int stall, input bit pulses);
    int exp_done, gap, gap_bad;
    logic [NB-1:0] obs_vec;
    exp_done = 1 + WPF * (1 + 2 * DIV * WW) + LAT + stall;
    words[0] = w0;
    words[1] = w1;
    @(posedge clk); #1;
    start_cyc = cyc;
    clear_mon();
    accepted = 0;
    gap = 0;
    gap_bad = 0;
    i_start = 1'b1;
    i_valid = 1'b1;
    i_data  = w0;
    for (int n = 1; n <= exp_done + 12; n++) begin
      @(posedge clk); #1;
      i_start = pulses && (n == 20 || n == exp_done - 3 || n == exp_done);
      if (accepted < WPF) i_data = words[accepted];
      else i_data = 16'($urandom);
      if (accepted == 1 && o_ready && gap < stall) begin
        i_valid = 1'b0;
        gap++;
        if (o_clk) gap_bad++;
      end else begin
        i_valid = 1'b1;
      end
    end
    i_start = 1'b0;
    obs_vec = '0;
    foreach (bits[i]) obs_vec = {obs_vec[NB-2:0], bits[i]};
    check({tag, "_edges"},      64'(bits.size()), 64'(NB));
    check({tag, "_bits"},       64'(obs_vec),     64'({w0, w1}));
    check({tag, "_lat_first"},  64'(lat_first),   64'(exp_done - LAT));
    check({tag, "_lat_len"},    64'(lat_count),   64'(LAT));
    check({tag, "_done_count"}, 64'(done_count),  64'd1);
    check({tag, "_done_cyc"},   64'(done_cyc),    64'(exp_done));
    check({tag, "_dai_stable"}, 64'(dai_viol),    64'd0);
    check({tag, "_phase_len"},  64'(phase_viol),  64'd0);
    check({tag, "_lat_clk"},    64'(lat_viol),    64'd0);
    check({tag, "_idle_ready"}, 64'(idle_viol),   64'd0);
    check({tag, "_gap_pins"},   64'(gap_bad),     64'd0);
    check({tag, "_gap_len"},    64'(gap),         64'(stall));
    check({tag, "_busy_end"},   64'(o_busy),      64'd0);
  endtask

  initial begin
    logic [WW-1:0] r0, r1;
    int st;

    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
    clear_mon();
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", 64'({o_ready, o_busy, o_done, o_clk, o_dai, o_lat}), 64'd0);
    i_rst = 1'b0;

    // i_valid with no start: nothing happens.
    clear_mon();
    i_valid = 1'b1;
    i_data = 16'hFFFF;
    repeat (6) @(posedge clk); #1;
    check("idle_valid_ready", 64'({o_ready, o_busy}), 64'd0);
    check("idle_valid_edges", 64'(bits.size()), 64'd0);

    run_frame("nominal", 16'hA5F0, 16'h0001, 0, 1'b0);
    run_frame("stall",   16'hA5F0, 16'h0001, 10, 1'b0);
    run_frame("ignored", 16'h3C96, 16'h8001, 0, 1'b1);

    // Reset in the middle of the first word.
    words[0] = 16'hA5F0;
    words[1] = 16'h0001;
    @(posedge clk); #1;
    start_cyc = cyc;
    clear_mon();
    accepted = 0;
    i_start = 1'b1;
    i_valid = 1'b1;
    i_data = words[0];
    for (int n = 1; n < 40; n++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      if (accepted < WPF) i_data = words[accepted];
    end
    @(posedge clk); #1;
    check("rst_pre_busy", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    #1;
    check("rst_async_outputs", 64'({o_ready, o_busy, o_done, o_clk, o_dai, o_lat}), 64'd0);
    repeat (3) @(posedge clk); #1;
    i_rst = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("rst_no_latch", 64'(lat_count), 64'd0);
    check("rst_no_done", 64'(done_count), 64'd0);
    check("rst_idle", 64'({o_ready, o_busy}), 64'd0);

    run_frame("post_rst", 16'hA5F0, 16'h0001, 0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      st = int'($urandom_range(0, 5));
      run_frame("random", r0, r1, st, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
